// File: rtl/q2_mem_arb_if.sv
// q2_mem_arb_if: request/acknowledge port between one bus master and the
// q2 memory arbiter. The master holds req/we/addr/wdata until ack; rdata is
// valid while ack=1 and held afterwards.
interface q2_mem_arb_if;
  logic        req;
  logic        we;
  logic [11:0] addr;
  logic [11:0] wdata;
  logic [11:0] rdata;
  logic        ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/q2_mem_arb.sv
// q2_mem_arb: two-master (CPU, DMA) arbiter and sequencer for the q2 12-bit
// single-port memory bus. Each access runs IDLE -> SETUP -> STROBE (WAIT
// cycles) -> ACK, so writes are latched by memory on the rising edge of wrm
// while address and data are already stable.
// Optional output register at 12'hFFF is built when Q2_MEM_ARB_OUTPORT_EN
// is defined; otherwise out_data/out_stb are tied to zero.
module q2_mem_arb #(
  parameter int WAIT = 1          // rdm/wrm active cycles per access, 1..7
) (
  input  logic              clk,
  input  logic              rst,  // asynchronous, active low
  q2_mem_arb_if.slave       cpu,
  q2_mem_arb_if.slave       dma,
  output logic [11:0]       abus,
  inout  wire  [11:0]       dbus,
  output logic              rdm,
  output logic              wrm,
  output logic [11:0]       out_data,
  output logic              out_stb
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, ACK} state_t;

  localparam logic [2:0] CNT_LOAD = 3'(WAIT - 1);

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic        gnt_reg, gnt_next;     // 0 = CPU owns the bus, 1 = DMA
  logic        last_reg, last_next;   // master granted most recently
  logic        we_reg, we_next;
  logic [11:0] addr_reg, addr_next;
  logic [11:0] wdata_reg, wdata_next;
  logic        rdm_reg, rdm_next;
  logic        wrm_reg, wrm_next;
  logic        oe_reg, oe_next;
  logic        cpu_ack_reg, cpu_ack_next;
  logic        dma_ack_reg, dma_ack_next;
  logic [11:0] cpu_rdata_reg, dma_rdata_reg;
  logic        take, pick;
  logic        last_strobe;

  // The final STROBE cycle is where read data is captured and ACK begins.
  assign last_strobe = (state_reg == STROBE) && (cnt_reg == 3'd0);

  // Next-state, grant selection and registered-output decode.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    gnt_next     = gnt_reg;
    last_next    = last_reg;
    we_next      = we_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    rdm_next     = 1'b0;
    wrm_next     = 1'b0;
    oe_next      = 1'b0;
    cpu_ack_next = 1'b0;
    dma_ack_next = 1'b0;
    take         = 1'b0;
    pick         = 1'b0;
    case (state_reg)
      IDLE: begin
        // On a tie the master not granted last time wins.
        if (cpu.req && (!dma.req || last_reg)) begin
          take = 1'b1;
          pick = 1'b0;
        end else if (dma.req) begin
          take = 1'b1;
          pick = 1'b1;
        end
        if (take) begin
          state_next = SETUP;
          gnt_next   = pick;
          last_next  = pick;
          we_next    = pick ? dma.we    : cpu.we;
          addr_next  = pick ? dma.addr  : cpu.addr;
          wdata_next = pick ? dma.wdata : cpu.wdata;
          oe_next    = we_next;
        end
      end
      SETUP: begin
        state_next = STROBE;
        cnt_next   = CNT_LOAD;
        rdm_next   = !we_reg;
        wrm_next   = we_reg;
        oe_next    = we_reg;
      end
      STROBE: begin
        if (cnt_reg == 3'd0) begin
          state_next   = ACK;
          cpu_ack_next = !gnt_reg;
          dma_ack_next = gnt_reg;
        end else begin
          cnt_next = cnt_reg - 3'd1;
          rdm_next = !we_reg;
          wrm_next = we_reg;
          oe_next  = we_reg;
        end
      end
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, latched access and registered bus outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= 3'd0;
      gnt_reg       <= 1'b0;
      last_reg      <= 1'b1;
      we_reg        <= 1'b0;
      addr_reg      <= 12'd0;
      wdata_reg     <= 12'd0;
      rdm_reg       <= 1'b0;
      wrm_reg       <= 1'b0;
      oe_reg        <= 1'b0;
      cpu_ack_reg   <= 1'b0;
      dma_ack_reg   <= 1'b0;
      cpu_rdata_reg <= 12'd0;
      dma_rdata_reg <= 12'd0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      gnt_reg     <= gnt_next;
      last_reg    <= last_next;
      we_reg      <= we_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      rdm_reg     <= rdm_next;
      wrm_reg     <= wrm_next;
      oe_reg      <= oe_next;
      cpu_ack_reg <= cpu_ack_next;
      dma_ack_reg <= dma_ack_next;
      // Only the granted master's read register sees bus data.
      if (last_strobe && !we_reg && !gnt_reg) cpu_rdata_reg <= dbus;
      if (last_strobe && !we_reg &&  gnt_reg) dma_rdata_reg <= dbus;
    end
  end

  assign abus      = addr_reg;
  assign rdm       = rdm_reg;
  assign wrm       = wrm_reg;
  assign dbus      = oe_reg ? wdata_reg : 12'bz;
  assign cpu.ack   = cpu_ack_reg;
  assign cpu.rdata = cpu_rdata_reg;
  assign dma.ack   = dma_ack_reg;
  assign dma.rdata = dma_rdata_reg;

`ifdef Q2_MEM_ARB_OUTPORT_EN
  logic [11:0] out_data_reg;
  logic        out_stb_reg;
  logic        out_hit;

  assign out_hit = last_strobe && we_reg && (addr_reg == 12'hFFF);

  // Output port register: loads on the edge entering ACK of a write to FFF.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data_reg <= 12'd0;
      out_stb_reg  <= 1'b0;
    end else begin
      out_stb_reg <= out_hit;
      if (out_hit) out_data_reg <= wdata_reg;
    end
  end

  assign out_data = out_data_reg;
  assign out_stb  = out_stb_reg;
`else
  assign out_data = 12'd0;
  assign out_stb  = 1'b0;
`endif

endmodule

// File: tb/tb_q2_mem_arb.sv
// tb_q2_mem_arb: directed bench for q2_mem_arb. One instance runs WAIT=1,
// a second runs WAIT=3; each has a small memory model on its bus that drives
// dbus while rdm=1 and stores dbus on the rising edge of wrm.
module tb_q2_mem_arb;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  q2_mem_arb_if cpu1 ();
  q2_mem_arb_if dma1 ();
  q2_mem_arb_if cpu3 ();
  q2_mem_arb_if dma3 ();

  logic [11:0] abus1, abus3, out_data1, out_data3;
  logic        rdm1, wrm1, out_stb1, rdm3, wrm3, out_stb3;
  wire  [11:0] dbus1, dbus3;
  logic [11:0] mem1 [0:4095];
  logic [11:0] mem3 [0:4095];

  q2_mem_arb #(.WAIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .cpu(cpu1), .dma(dma1),
    .abus(abus1), .dbus(dbus1), .rdm(rdm1), .wrm(wrm1),
    .out_data(out_data1), .out_stb(out_stb1)
  );

  q2_mem_arb #(.WAIT(3)) u_dut3 (
    .clk(clk), .rst(rst), .cpu(cpu3), .dma(dma3),
    .abus(abus3), .dbus(dbus3), .rdm(rdm3), .wrm(wrm3),
    .out_data(out_data3), .out_stb(out_stb3)
  );

  // Memory models.
  assign dbus1 = rdm1 ? mem1[abus1] : 12'bz;
  assign dbus3 = rdm3 ? mem3[abus3] : 12'bz;
  always @(posedge wrm1) mem1[abus1] = dbus1;
  always @(posedge wrm3) mem3[abus3] = dbus3;

  // Count out_stb pulses on the WAIT=1 instance.
  int stb_total = 0;
  int stb_with_ack = 0;
  always @(negedge clk) begin
    if (out_stb1) begin
      stb_total++;
      if (cpu1.ack) stb_with_ack++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One access on the WAIT=1 instance, starting from an IDLE cycle.
  task automatic acc1(input logic is_dma, input logic we, input logic [11:0] addr,
                      input logic [11:0] wdata, output int ack_cyc, output int stb_cyc,
                      output logic [11:0] rd, output int other, output logic [11:0] bus_wr);
    @(posedge clk); #1;
    if (is_dma) begin
      dma1.req = 1'b1; dma1.we = we; dma1.addr = addr; dma1.wdata = wdata;
    end else begin
      cpu1.req = 1'b1; cpu1.we = we; cpu1.addr = addr; cpu1.wdata = wdata;
    end
    ack_cyc = -1; stb_cyc = 0; rd = 12'd0; other = 0; bus_wr = 12'd0;
    for (int c = 1; c <= 20 && ack_cyc < 0; c++) begin
      @(posedge clk); #1;
      if (rdm1 || wrm1) stb_cyc++;
      if (wrm1) bus_wr = dbus1;
      if (is_dma ? cpu1.ack : dma1.ack) other++;
      if (is_dma ? dma1.ack : cpu1.ack) begin
        ack_cyc = c;
        rd = is_dma ? dma1.rdata : cpu1.rdata;
      end
    end
    cpu1.req = 1'b0;
    dma1.req = 1'b0;
    $display("access %s we=%0d addr=%03h wdata=%03h ack_cycle=%0d rdata=%03h",
             is_dma ? "dma" : "cpu", we, addr, wdata, ack_cyc, rd);
  endtask

  int          ac, sc, oth;
  logic [11:0] rd, bw;
  int          who [0:3];
  int          when [0:3];
  int          n_ack, both;
  int          cpu_ac, dma_ac, r_cnt, r_first, r_last, oth3;
  logic [11:0] cpu_rd, dma_rd, cpu_rd_after;
  logic        saw_wrm;

  initial begin
    cpu1.req = 0; cpu1.we = 0; cpu1.addr = 0; cpu1.wdata = 0;
    dma1.req = 0; dma1.we = 0; dma1.addr = 0; dma1.wdata = 0;
    cpu3.req = 0; cpu3.we = 0; cpu3.addr = 0; cpu3.wdata = 0;
    dma3.req = 0; dma3.we = 0; dma3.addr = 0; dma3.wdata = 0;
    mem1[12'h011] = 12'h456;
    mem1[12'h020] = 12'h777;
    mem3[12'h7FF] = 12'hABC;

    // Reset values.
    repeat (2) @(posedge clk); #1;
    chk("rst_abus", abus1, 0);
    chk("rst_rdm_wrm", {rdm1, wrm1}, 0);
    chk("rst_acks", {cpu1.ack, dma1.ack}, 0);
    chk("rst_rdata", {cpu1.rdata, dma1.rdata}, 0);
    chk("rst_out", {out_data1, out_stb1}, 0);
    $display("reset state checked");

    // Contention from reset: both requests held, grants alternate.
    cpu1.req = 1; cpu1.we = 0; cpu1.addr = 12'h100;
    dma1.req = 1; dma1.we = 0; dma1.addr = 12'h200;
    rst = 1;
    n_ack = 0; both = 0;
    for (int i = 0; i < 4; i++) begin who[i] = -1; when[i] = -1; end
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      if (cpu1.ack && dma1.ack) both++;
      if ((cpu1.ack || dma1.ack) && n_ack < 4) begin
        who[n_ack] = dma1.ack ? 1 : 0;
        when[n_ack] = c;
        n_ack++;
      end
    end
    cpu1.req = 0; dma1.req = 0;
    $display("contention acks: %0d@%0d %0d@%0d %0d@%0d %0d@%0d",
             who[0], when[0], who[1], when[1], who[2], when[2], who[3], when[3]);
    chk("rr_who0", who[0], 0);
    chk("rr_who1", who[1], 1);
    chk("rr_who2", who[2], 0);
    chk("rr_who3", who[3], 1);
    chk("rr_when0", when[0], 3);
    chk("rr_when1", when[1], 7);
    chk("rr_when3", when[3], 15);
    chk("rr_both_acks", both, 0);

    // CPU write then read, WAIT=1.
    acc1(0, 1, 12'h010, 12'h5A3, ac, sc, rd, oth, bw);
    chk("wr_ack_cycle", ac, 3);
    chk("wr_strobe_len", sc, 1);
    chk("wr_dbus", bw, 12'h5A3);
    chk("wr_dma_ack", oth, 0);
    chk("wr_mem", mem1[12'h010], 12'h5A3);
    acc1(0, 0, 12'h010, 12'h000, ac, sc, rd, oth, bw);
    chk("rd_ack_cycle", ac, 3);
    chk("rd_strobe_len", sc, 1);
    chk("rd_data", rd, 12'h5A3);
    chk("rd_dma_ack", oth, 0);

    // CPU drops req during SETUP; DMA requests during CPU STROBE.
    @(posedge clk); #1;
    cpu1.req = 1; cpu1.we = 0; cpu1.addr = 12'h011;
    cpu_ac = -1; dma_ac = -1; cpu_rd = 0; dma_rd = 0; cpu_rd_after = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c == 1) cpu1.req = 0;
      if (c == 2) begin dma1.req = 1; dma1.we = 0; dma1.addr = 12'h020; end
      if (cpu1.ack) begin cpu_ac = c; cpu_rd = cpu1.rdata; end
      if (dma1.ack) begin
        dma_ac = c; dma_rd = dma1.rdata; cpu_rd_after = cpu1.rdata; dma1.req = 0;
      end
    end
    $display("late/drop: cpu ack %0d rdata=%03h, dma ack %0d rdata=%03h",
             cpu_ac, cpu_rd, dma_ac, dma_rd);
    chk("drop_cpu_ack", cpu_ac, 3);
    chk("drop_cpu_rdata", cpu_rd, 12'h456);
    chk("late_dma_ack", dma_ac, 7);
    chk("late_dma_rdata", dma_rd, 12'h777);
    chk("cpu_rdata_kept", cpu_rd_after, 12'h456);

    // WAIT=3 DMA read.
    @(posedge clk); #1;
    dma3.req = 1; dma3.we = 0; dma3.addr = 12'h7FF;
    ac = -1; r_cnt = 0; r_first = -1; r_last = -1; oth3 = 0; rd = 0;
    for (int c = 1; c <= 12 && ac < 0; c++) begin
      @(posedge clk); #1;
      if (rdm3) begin
        r_cnt++;
        if (r_first < 0) r_first = c;
        r_last = c;
      end
      if (cpu3.ack) oth3++;
      if (dma3.ack) begin ac = c; rd = dma3.rdata; dma3.req = 0; end
    end
    dma3.req = 0;
    $display("wait3 dma read: rdm %0d cycles, ack cycle %0d, rdata=%03h", r_cnt, ac, rd);
    chk("w3_rdm_cycles", r_cnt, 3);
    chk("w3_rdm_span", r_last - r_first + 1, 3);
    chk("w3_ack_cycle", ac, 5);
    chk("w3_rdata", rd, 12'hABC);
    chk("w3_cpu_ack", oth3, 0);

    // Write to FFF: output port when enabled, ordinary memory always.
    acc1(0, 1, 12'hFFF, 12'h02A, ac, sc, rd, oth, bw);
    chk("fff_ack_cycle", ac, 3);
    chk("fff_mem", mem1[12'hFFF], 12'h02A);
`ifdef Q2_MEM_ARB_OUTPORT_EN
    chk("out_data", out_data1, 12'h02A);
    chk("out_stb_at_ack", stb_with_ack, 1);
    @(posedge clk); #1;
    chk("out_stb_pulses", stb_total, 1);
    chk("out_stb_low", out_stb1, 0);
`else
    chk("out_data_zero", out_data1, 0);
    @(posedge clk); #1;
    chk("out_stb_pulses", stb_total, 0);
`endif

    // Reset asserted mid-write.
    @(posedge clk); #1;
    cpu1.req = 1; cpu1.we = 1; cpu1.addr = 12'h030; cpu1.wdata = 12'h3C3;
    saw_wrm = 0;
    for (int c = 1; c <= 5 && !saw_wrm; c++) begin
      @(posedge clk); #1;
      if (wrm1) saw_wrm = 1;
    end
    chk("mid_saw_wrm", saw_wrm, 1);
    #2 rst = 0;
    #1;
    $display("reset asserted mid-write");
    chk("mid_wrm", wrm1, 0);
    chk("mid_rdm", rdm1, 0);
    chk("mid_abus", abus1, 0);
    chk("mid_rdata", {cpu1.rdata, dma1.rdata}, 0);
    chk("mid_out", {out_data1, out_stb1}, 0);
    cpu1.req = 0;
    @(posedge clk); #1;
    rst = 1;
    acc1(0, 0, 12'h010, 12'h000, ac, sc, rd, oth, bw);
    chk("post_rst_ack", ac, 3);
    chk("post_rst_rdata", rd, 12'h5A3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/q2_mem_arb.md
Name: q2_mem_arb

Overview:
- Two-master arbiter and bus sequencer for the q2 12-bit single-port memory bus (abus, dbus, rdm, wrm).
- Shares memory between the q2 core (CPU port) and a front-panel/loader DMA port.
- Generates setup/strobe/release timing so the memory latches writes on the rising edge of wrm.
- Provides the optional memory-mapped output register at address 12'hFFF.

Parameters:
- WAIT, 1: number of cycles rdm/wrm stay asserted per access; legal range 1..7.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held with cpu_we/addr/wdata stable until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  12  word address.
- cpu_wdata  in  12  write data.
- cpu_rdata  out  12  read data; valid while cpu_ack=1, then held.
- cpu_ack  out  1  one-cycle completion pulse.
- dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ack: same meanings and widths as the cpu_* ports, for the DMA master.
- abus  out  12  memory address.
- dbus  inout  12  memory data; driven only during write SETUP/STROBE, otherwise high-Z.
- rdm  out  1  memory read strobe.
- wrm  out  1  memory write strobe.
- out_data  out  12  last value written to 12'hFFF (optional feature).
- out_stb  out  1  one-cycle pulse when out_data updates (optional feature).

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - rdm=wrm=0 immediately, dbus released.
  - abus=0, both acks=0, both rdata=0, out_data=0, out_stb=0, last_grant=DMA, so the CPU wins the first tie.
- States: IDLE -> SETUP -> STROBE (WAIT cycles) -> ACK -> IDLE.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that master.
  - Both requesting: grant the master not named by last_grant (round-robin). last_grant updates on grant.
  - On grant, latch we/addr/wdata from the granted master into internal registers. The master's inputs are ignored from then on.
- SETUP (1 cycle):
  - abus = latched addr.
  - On a write, dbus = latched wdata.
  - rdm=wrm=0.
- STROBE (WAIT cycles, counted by a 3-bit counter):
  - Read: rdm=1, dbus high-Z; dbus is sampled into the granted master's rdata register at the last STROBE edge.
  - Write: wrm=1, dbus driven.
  - abus is held throughout.
- ACK (1 cycle):
  - rdm=wrm=0, dbus high-Z, abus held.
  - Granted master's ack=1; the other ack stays 0.
- Latency: a request sampled in IDLE at edge 0 gives ack high in cycle 2+WAIT. With WAIT=1, ack is high in the 3rd cycle after the sampling edge. Throughput is one access per 3+WAIT cycles.
- Request held after ack: if req is still high in the IDLE cycle after ACK, it is a new access. Masters must drop req on ack for a single access.
- Request dropped before grant: nothing happens.
- Request dropped after grant: the access completes and ack is still pulsed.
- Simultaneous events: a request arriving during a non-IDLE state waits. There is no preemption. Both acks are never high together.
- rdata of the non-granted master is unchanged by another master's read.
- Addresses wrap naturally at 12 bits; 12'hFFF is a normal memory location.
- Outputs: rdm, wrm, acks and abus are registered. The dbus output enable is registered.

Optional Feature:
- Macro Q2_MEM_ARB_OUTPORT_EN.
- Defined: any write to 12'hFFF (either master) loads out_data with the write data at the ACK edge, and out_stb=1 for that ACK cycle. The write still goes to memory.
- Not defined: out_data is constant 0, out_stb is constant 0, and no extra logic is generated.

Test Plan:
- Reset mid-write: assert rst=0 while wrm=1 -> wrm=0 and dbus=Z in the same cycle without waiting for clk; all outputs return to reset values; the first access after release runs normally.
- CPU write then read, WAIT=1: write 12'h5A3 to 12'h010, then read 12'h010 -> wrm high exactly 1 cycle, ack in 3rd cycle after request; cpu_rdata=12'h5A3 with cpu_ack=1; dma_ack stays 0.
- Contention: cpu_req and dma_req rise on the same edge from reset -> CPU granted first, DMA second.
  - Both held continuously: grants alternate CPU, DMA, CPU, DMA.
  - Acks are spaced 4 cycles apart.
- WAIT=3: DMA read of 12'hABC preloaded at 12'h7FF -> rdm high 3 consecutive cycles, dma_ack in cycle 5, dma_rdata=12'hABC.
- Late request and drop: DMA request arriving during a CPU STROBE -> DMA is served immediately after the CPU's ACK.
  - CPU dropping req during SETUP -> its access still completes and cpu_ack is pulsed.
- Q2_MEM_ARB_OUTPORT_EN defined: CPU write 12'h02A to 12'hFFF -> out_data=12'h02A and a 1-cycle out_stb at ack; memory[FFF]=12'h02A.
  - Macro undefined: out_data=0 and out_stb=0 throughout.
